// File: rtl/udma_apb_bridge.sv
// Registered APB-to-peripheral bridge for the uDMA configuration register
// files. It decodes one APB access onto one of N peripheral ports and holds
// the peripheral address, data and direction stable for the whole access.
// It also adds a bounded-wait timeout and a slave error for out-of-range selects.
module udma_apb_bridge #(
   parameter int unsigned APB_ADDR_WIDTH    = 12,
   parameter int unsigned N_PERIPHS         = 8,
   parameter int unsigned PERIPH_ADDR_WIDTH = 5,
   parameter int unsigned TIMEOUT_CYCLES    = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [APB_ADDR_WIDTH-1:0]         PADDR,
   input  logic [31:0]                       PWDATA,
   input  logic                              PWRITE,
   input  logic                              PSEL,
   input  logic                              PENABLE,
   output logic [31:0]                       PRDATA,
   output logic                              PREADY,
   output logic                              PSLVERR,
   output logic [PERIPH_ADDR_WIDTH-1:0]      periph_addr_o,
   output logic [31:0]                       periph_data_o,
   output logic                              periph_rwn_o,
   output logic [N_PERIPHS-1:0]              periph_valid_o,
   input  logic [N_PERIPHS-1:0][31:0]        periph_data_i,
   input  logic [N_PERIPHS-1:0]              periph_ready_i
);

   localparam int unsigned SEL_W = (N_PERIPHS > 1) ? $clog2(N_PERIPHS) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t                         state_q, state_d;
   logic [SEL_W-1:0]               sel_q, sel_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [PERIPH_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]                    data_q, data_d;
   logic                           rwn_q, rwn_d;
   logic [N_PERIPHS-1:0]           valid_q, valid_d;
   logic [31:0]                    prdata_q, prdata_d;
   logic                           pready_q, pready_d;
   logic                           pslverr_q, pslverr_d;

   logic [SEL_W-1:0]               sel_in;
   logic                           sel_in_range;
   logic                           rdy_sel;
   logic [31:0]                    dat_sel;
   logic                           cnt_expired;

   assign sel_in       = PADDR[PERIPH_ADDR_WIDTH+2 +: SEL_W];
   assign sel_in_range = (32'(sel_in) < N_PERIPHS);
   assign cnt_expired  = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 1);

   // Pick ready/data of the latched peripheral; all other ports are ignored.
   always_comb begin
      rdy_sel = 1'b0;
      dat_sel = '0;
      for (int unsigned i = 0; i < N_PERIPHS; i++) begin
         if (32'(sel_q) == i) begin
            rdy_sel = periph_ready_i[i];
            dat_sel = periph_data_i[i];
         end
      end
   end

   // Next-state and next-output logic; response outputs default to 0 so they
   // only pulse for the single RESP cycle.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rwn_d     = rwn_q;
      valid_d   = valid_q;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (PSEL && PENABLE) begin
               sel_d  = sel_in;
               addr_d = PADDR[PERIPH_ADDR_WIDTH+1:2];
               data_d = PWDATA;
               rwn_d  = ~PWRITE;
               if (sel_in_range) begin
                  for (int unsigned i = 0; i < N_PERIPHS; i++) begin
                     valid_d[i] = (32'(sel_in) == i);
                  end
                  state_d = ACCESS;
               end else begin
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
                  state_d   = RESP;
               end
            end
         end
         ACCESS: begin
            // Ready is checked before the timeout so a coincident ready wins.
            if (rdy_sel) begin
               valid_d   = '0;
               prdata_d  = rwn_q ? dat_sel : '0;
               pready_d  = 1'b1;
               state_d   = RESP;
            end else if (cnt_expired) begin
               valid_d   = '0;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         rwn_q     <= 1'b0;
         valid_q   <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         rwn_q     <= rwn_d;
         valid_q   <= valid_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign PRDATA         = prdata_q;
   assign PREADY         = pready_q;
   assign PSLVERR        = pslverr_q;
   assign periph_addr_o  = addr_q;
   assign periph_data_o  = data_q;
   assign periph_rwn_o   = rwn_q;
   assign periph_valid_o = valid_q;

endmodule
